shift_add_ctrl: RTL and testbench

- Sequencer for the shift-add multiplier datapath (accumulator A, multiplicand M, multiplier Q).
- Accepts a start request and drives the datapath commands ld_regs, add_en and shift_en, one iteration per multiplier bit.
- Reads the datapath's q0 decision bit and reports busy/done to the requesting master.
- The product is taken directly from the datapath output while done is high.

---
 rtl/shift_add_pkg.sv | 21 ++
 rtl/mul_bit_counter.sv | 37 +++
 rtl/shift_add_ctrl.sv | 111 +++++++++++
 tb/tb_shift_add_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_pkg.sv
// rtl/shift_add_pkg.sv - shared state encoding and sizing helpers for the shift-add sequencer
package shift_add_pkg;

    localparam int WIDTH_DEF = 4;

    // S_ITER exists only in FAST_CHECK_EN builds; S_CHECK only in the default build.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5,
        S_ITER  = 3'd6
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_bit_counter.sv
// rtl/mul_bit_counter.sv - loadable down-counter tracking remaining multiplier bits
module mul_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             is_one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o  = cnt_q;
    assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_add_ctrl.sv
// rtl/shift_add_ctrl.sv - shift-add multiplier sequencer; FAST_CHECK_EN merges CHECK into a Mealy ITER state
module shift_add_ctrl
    import shift_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    output logic ld_regs,
    output logic add_en,
    output logic shift_en,
    output logic busy,
    output logic done
);

    localparam int CNT_W = cnt_width(WIDTH);

`ifdef FAST_CHECK_EN
    localparam state_e DECIDE_STATE = S_ITER;
`else
    localparam state_e DECIDE_STATE = S_CHECK;
`endif

    state_e           state_q;
    state_e           state_d;
    logic             cnt_load;
    logic             dec_req;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic [CNT_W-1:0] cnt_value;

    // Never let a stray decrement wrap the counter past zero.
    assign cnt_dec = dec_req && (cnt_value != '0);

    mul_bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(WIDTH)),
        .dec_i      (cnt_dec),
        .value_o    (cnt_value),
        .is_one_o   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_regs  = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cnt_load = 1'b0;
        dec_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                ld_regs  = 1'b1;
                busy     = 1'b1;
                cnt_load = 1'b1;
                state_d  = DECIDE_STATE;
            end
`ifdef FAST_CHECK_EN
            S_ITER: begin
                busy = 1'b1;
                if (q0) begin
                    add_en  = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    shift_en = 1'b1;
                    dec_req  = 1'b1;
                    state_d  = cnt_is_one ? S_DONE : S_ITER;
                end
            end
`else
            S_CHECK: begin
                busy    = 1'b1;
                state_d = q0 ? S_ADD : S_SHIFT;
            end
`endif
            S_ADD: begin
                busy    = 1'b1;
                add_en  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                dec_req  = 1'b1;
                state_d  = cnt_is_one ? S_DONE : DECIDE_STATE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// tb/tb_shift_add_ctrl.sv - scoreboard bench for shift_add_ctrl with a behavioural datapath
module tb_shift_add_ctrl;

    localparam int W = 4;
`ifdef FAST_CHECK_EN
    localparam int CYC_PER_BIT = 1;
`else
    localparam int CYC_PER_BIT = 2;
`endif

    typedef struct {
        int a;
        int b;
    } op_t;

    typedef struct {
        int prod;
        int lat;
        int adds;
        bit hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic q0;
    logic ld_regs;
    logic add_en;
    logic shift_en;
    logic busy;
    logic done;

    op_t  ops_q[$];
    exp_t exp_q[$];
    int   checks    = 0;
    int   passed    = 0;
    int   viol      = 0;
    int   n_issued  = 0;
    int   n_results = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;

    shift_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q0       (q0),
        .ld_regs  (ld_regs),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done)
    );

    // Datapath: carry-extended accumulator, multiplicand, multiplier.
    logic [W:0]     acc = '0;
    logic [W-1:0]   mc  = '0;
    logic [W-1:0]   mq  = '0;
    logic [2*W-1:0] product;
    op_t            dp_op;

    assign q0      = mq[0];
    assign product = {acc[W-1:0], mq};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ld_regs) begin
            if (ops_q.size() > 0) dp_op = ops_q.pop_front();
            else dp_op = '{0, 0};
            mc  <= W'(dp_op.a);
            mq  <= W'(dp_op.b);
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + {1'b0, mc};
        end else if (shift_en) begin
            {acc, mq} <= {acc, mq} >> 1;
        end
    end

    function automatic exp_t model(input int a, input int b, input bit hold);
        exp_t e;
        int   pop;
        pop = 0;
        for (int i = 0; i < W; i++) if ((b >> i) & 1) pop++;
        e.prod = a * b;
        e.adds = pop;
        e.lat  = 1 + CYC_PER_BIT * W + pop;
        e.hold = hold;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Monitor / scoreboard
    int   n_ld = 0, n_add = 0, n_shift = 0, ld_cyc = 0;
    bit   done_prev = 1'b0;
    bit   want_b2b  = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
            want_b2b  = 1'b0;
            n_ld      = 0;
        end else begin
            if ((add_en && shift_en) || (ld_regs && (add_en || shift_en)) || (busy && done)) viol++;
            if (want_b2b) begin
                chk("b2b_load_after_done", int'({ld_regs, done}), 2);
                want_b2b = 1'b0;
            end
            if (ld_regs) begin
                n_ld++;
                n_add   = 0;
                n_shift = 0;
                ld_cyc  = cyc;
            end else begin
                if (add_en) n_add++;
                if (shift_en) n_shift++;
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("product", int'(product), mon_e.prod);
                    chk("latency", cyc - ld_cyc, mon_e.lat);
                    chk("add_count", n_add, mon_e.adds);
                    chk("shift_count", n_shift, W);
                    chk("ld_count", n_ld, 1);
                    want_b2b = mon_e.hold;
                end
                n_ld = 0;
                n_results++;
            end
            done_prev = done;
        end
    end

    task automatic issue(input int a, input int b, input bit hold);
        ops_q.push_back('{a, b});
        exp_q.push_back(model(a, b, hold));
        n_issued++;
    endtask

    task automatic wait_results();
        int t;
        t = 0;
        while (n_results < n_issued && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (n_results < n_issued) begin
            chk("result_timeout", n_results, n_issued);
            exp_q.delete();
            ops_q.delete();
            n_issued = n_results;
        end
    endtask

    task automatic run_one(input int a, input int b);
        @(negedge clk);
        issue(a, b, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_results();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int t;
        int nb;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({busy, done, ld_regs, add_en, shift_en}), 0);
        rst = 1'b0;

        run_one(13, 11);
        run_one(9, 0);
        run_one(15, 15);

        // start held across three back-to-back operations
        @(negedge clk);
        issue(7, 3, 1'b1);
        issue(2, 5, 1'b1);
        issue(15, 1, 1'b0);
        start = 1'b1;
        cnt = 0;
        t = 0;
        while (cnt < 3 && t < 300) begin
            @(negedge clk);
            t++;
            if (done) cnt++;
        end
        start = 1'b0;
        chk("held_done_pulses", cnt, 3);
        wait_results();

        // reset in the 5th busy cycle of 6x6
        @(negedge clk);
        ops_q.push_back('{6, 6});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = busy ? 1 : 0;
        t = 0;
        while (nb < 5 && t < 50) begin
            @(negedge clk);
            t++;
            if (busy) nb++;
        end
        chk("busy_cycles_before_reset", nb, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_op_reset_outputs", int'({busy, done, ld_regs, add_en, shift_en}), 0);
        @(negedge clk);
        rst = 1'b0;
        ops_q.delete();
        run_one(6, 6);

        // start pulsed while busy is ignored
        @(negedge clk);
        issue(5, 5, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_results();

        for (int i = 0; i < 20; i++) begin
            run_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        repeat (2) @(negedge clk);
        chk("invariant_violations", viol, 0);
        chk("leftover_expected", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
